operand_fetch: RTL and testbench

- Read-side initiator for the integer register file: drives both read addresses, captures operands into a valid/ready pipeline register, and forces x0 to zero.
- Tracks in-flight register writes with a per-register busy scoreboard and stalls decode on read-after-write hazards.
- Sits between decode and execute. The writeback stage reports completions to it.

---
 rtl/operand_fetch_pkg.sv | 17 +
 rtl/operand_fetch_if.sv | 53 +++++
 rtl/opf_scoreboard.sv | 72 +++++++
 rtl/operand_fetch.sv | 90 +++++++++
 tb/tb_operand_fetch.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants and the execute-side operand bundle for the operand fetch stage.
package operand_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } opf_bundle_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand fetch stage.
// slave is the operand fetch side; master is the surrounding pipeline.
interface operand_fetch_if import operand_fetch_pkg::*; #(
  parameter int N = XLEN,
  parameter int M = REG_AW
);

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_rs1;
  logic [M-1:0] in_rs2;
  logic [M-1:0] in_rd;
  logic         in_rd_we;
  logic [N-1:0] in_imm;

  logic [M-1:0] rf_adrs_r1;
  logic [M-1:0] rf_adrs_r2;
  logic [N-1:0] rf_data_r1;
  logic [N-1:0] rf_data_r2;

  logic         wb_valid;
  logic [M-1:0] wb_adrs;
  logic [N-1:0] wb_data;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_op_a;
  logic [N-1:0] out_op_b;
  logic [N-1:0] out_imm;
  logic [M-1:0] out_rd;
  logic         out_rd_we;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_imm,
    output in_ready,
    output rf_adrs_r1, rf_adrs_r2,
    input  rf_data_r1, rf_data_r2,
    input  wb_valid, wb_adrs, wb_data,
    output out_valid, out_op_a, out_op_b, out_imm, out_rd, out_rd_we,
    input  out_ready
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_imm,
    input  in_ready,
    input  rf_adrs_r1, rf_adrs_r2,
    output rf_data_r1, rf_data_r2,
    output wb_valid, wb_adrs, wb_data,
    input  out_valid, out_op_a, out_op_b, out_imm, out_rd, out_rd_we,
    output out_ready
  );

endinterface

// File: rtl/opf_scoreboard.sv
// Per-register busy scoreboard with pending lookups for two source addresses.
// OPF_BYPASS_EN: a writeback arriving this cycle resolves the pending state of its register.
module opf_scoreboard import operand_fetch_pkg::*; #(
  parameter int M = REG_AW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  logic [M-1:0] set_adrs,
  input  logic         wb_valid,
  input  logic [M-1:0] wb_adrs,
  input  logic         young_valid,
  input  logic [M-1:0] young_adrs,
  input  logic [M-1:0] look_a,
  input  logic [M-1:0] look_b,
  output logic         pend_a,
  output logic         pend_b,
  output logic         err_spurious_wb
);

  localparam int NREG = 2 ** M;

  logic [NREG-1:0] busy;
  logic            wb_live;
  logic            set_live;

  assign wb_live  = wb_valid && (wb_adrs != '0);
  assign set_live = set_en && (set_adrs != '0);

  function automatic logic pend_of(
    input logic [M-1:0]    r,
    input logic [NREG-1:0] bsy,
    input logic            wv,
    input logic [M-1:0]    wa,
    input logic            yv,
    input logic [M-1:0]    ya
  );
    logic young;
    logic held;
    young = yv && (ya == r);
`ifdef OPF_BYPASS_EN
    held = bsy[r] && !(wv && (wa == r));
`else
    held = bsy[r] && !(wv && 1'b0) && (wa == wa);
`endif
    return (r != '0) && (held || young);
  endfunction

  always_comb begin
    pend_a = pend_of(look_a, busy, wb_valid, wb_adrs, young_valid, young_adrs);
    pend_b = pend_of(look_b, busy, wb_valid, wb_adrs, young_valid, young_adrs);
  end

  // set is applied after clear so a newer producer wins over a completing older one
  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= '0;
      err_spurious_wb <= 1'b0;
    end else begin
      if (wb_live) begin
        busy[wb_adrs] <= 1'b0;
        if (!busy[wb_adrs]) begin
          err_spurious_wb <= 1'b1;
        end
      end
      if (set_live) begin
        busy[set_adrs] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads both sources, zeroes x0, stalls on RAW hazards, holds operands for execute.
// OPF_BYPASS_EN: forwards same-cycle writeback data into the operands.
module operand_fetch import operand_fetch_pkg::*; #(
  parameter int N = XLEN,
  parameter int M = REG_AW
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  operand_fetch_if.slave bus,
  output logic err_spurious_wb
);

  logic         valid_q;
  opf_bundle_t  out_q;
  logic         pend_rs1;
  logic         pend_rs2;
  logic         hazard;
  logic         accept;
  logic         handoff;
  logic [N-1:0] op_a_sel;
  logic [N-1:0] op_b_sel;

  assign bus.rf_adrs_r1 = bus.in_rs1;
  assign bus.rf_adrs_r2 = bus.in_rs2;

  assign hazard       = pend_rs1 || pend_rs2;
  assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign handoff      = valid_q && bus.out_ready && !flush;

  opf_scoreboard #(.M(M)) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .set_en          (handoff && out_q.rd_we),
    .set_adrs        (out_q.rd),
    .wb_valid        (bus.wb_valid),
    .wb_adrs         (bus.wb_adrs),
    .young_valid     (valid_q && out_q.rd_we),
    .young_adrs      (out_q.rd),
    .look_a          (bus.in_rs1),
    .look_b          (bus.in_rs2),
    .pend_a          (pend_rs1),
    .pend_b          (pend_rs2),
    .err_spurious_wb (err_spurious_wb)
  );

  always_comb begin
    op_a_sel = bus.rf_data_r1;
    op_b_sel = bus.rf_data_r2;
`ifdef OPF_BYPASS_EN
    if (bus.wb_valid && (bus.wb_adrs == bus.in_rs1)) begin
      op_a_sel = bus.wb_data;
    end
    if (bus.wb_valid && (bus.wb_adrs == bus.in_rs2)) begin
      op_b_sel = bus.wb_data;
    end
`endif
    if (bus.in_rs1 == REG_ZERO) begin
      op_a_sel = '0;
    end
    if (bus.in_rs2 == REG_ZERO) begin
      op_b_sel = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      out_q.op_a  <= op_a_sel;
      out_q.op_b  <= op_b_sel;
      out_q.imm   <= bus.in_imm;
      out_q.rd    <= bus.in_rd;
      out_q.rd_we <= bus.in_rd_we;
    end else if (flush || bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_op_a  = out_q.op_a;
  assign bus.out_op_b  = out_q.op_b;
  assign bus.out_imm   = out_q.imm;
  assign bus.out_rd    = out_q.rd;
  assign bus.out_rd_we = out_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: queue-based reference of the output register, busy set and register file.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic err_spurious_wb;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .bus             (ifc),
    .err_spurious_wb (err_spurious_wb)
  );

  always #5 clk = ~clk;

`ifdef OPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] rf [32];
  assign ifc.rf_data_r1 = rf[ifc.rf_adrs_r1];
  assign ifc.rf_data_r2 = rf[ifc.rf_adrs_r2];

  opf_bundle_t q[$];
  bit          mb[32];
  bit          m_err;
  bit          started;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend(input logic [4:0] r, input bit wv, input logic [4:0] wa);
    if (r == 5'd0) return 1'b0;
    if ((q.size() > 0) && q[0].rd_we && (q[0].rd == r)) return 1'b1;
    if (BYP && wv && (wa == r)) return 1'b0;
    return mb[r];
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input bit wv, input logic [4:0] wa,
                                       input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (BYP && wv && (wa == r)) return wd;
    return rf[r];
  endfunction

  // one clock of stimulus; called at a falling edge, returns at the next falling edge
  task automatic cycle(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit we, input logic [31:0] imm, input bit ordy, input bit fl,
                       input bit wv, input logic [4:0] wa, input logic [31:0] wd, output bit rdy);
    bit          exp_rdy;
    bit          acc;
    bit          hand;
    logic [4:0]  hrd;
    opf_bundle_t nb;
    ifc.in_valid  = v;
    ifc.in_rs1    = rs1;
    ifc.in_rs2    = rs2;
    ifc.in_rd     = rd;
    ifc.in_rd_we  = we;
    ifc.in_imm    = imm;
    ifc.out_ready = ordy;
    flush         = fl;
    ifc.wb_valid  = wv;
    ifc.wb_adrs   = wa;
    ifc.wb_data   = wd;
    #1;
    exp_rdy = ((q.size() == 0) || ordy) && !pend(rs1, wv, wa) && !pend(rs2, wv, wa) && !fl;
    rdy = ifc.in_ready;
    chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    nb = '{op_a: opnd(rs1, wv, wa, wd), op_b: opnd(rs2, wv, wa, wd), imm: imm, rd: rd, rd_we: we};
    hand = (q.size() > 0) && ordy && !fl && q[0].rd_we && (q[0].rd != 5'd0);
    hrd = (q.size() > 0) ? q[0].rd : 5'd0;
    @(posedge clk);
    #1;
    if (wv && (wa != 5'd0)) begin
      if (!mb[wa]) m_err = 1'b1;
      mb[wa] = 1'b0;
      rf[wa] = wd;
    end
    if (hand) mb[hrd] = 1'b1;
    if (acc) q.push_back(nb);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    bit r;
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, ordy, 1'b0, 1'b0, 5'd0, 32'd0, r);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_rs1    = 5'd3;
    ifc.in_rs2    = 5'd4;
    ifc.in_rd     = 5'd5;
    ifc.in_rd_we  = 1'b1;
    ifc.in_imm    = 32'h0BAD_F00D;
    ifc.out_ready = 1'b1;
    flush         = 1'b0;
    ifc.wb_valid  = 1'b0;
    ifc.wb_adrs   = 5'd0;
    ifc.wb_data   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    foreach (mb[i]) mb[i] = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_op_a", ifc.out_op_a, 32'd0);
    chk("rst_op_b", ifc.out_op_b, 32'd0);
    chk("rst_imm", ifc.out_imm, 32'd0);
    chk("rst_rd", 32'(ifc.out_rd), 32'd0);
    chk("rst_err", 32'(err_spurious_wb), 32'd0);
    rst = 1'b0;
    started = 1'b1;
  endtask

  // monitor: compares the presented output against the queue head, retires it when it leaves
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started && !rst) begin
        chk("out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("out_op_a", ifc.out_op_a, q[0].op_a);
          chk("out_op_b", ifc.out_op_b, q[0].op_b);
          chk("out_imm", ifc.out_imm, q[0].imm);
          chk("out_rd", 32'(ifc.out_rd), 32'(q[0].rd));
          chk("out_rd_we", 32'(ifc.out_rd_we), 32'(q[0].rd_we));
          if (ifc.out_ready || flush) void'(q.pop_front());
        end
        chk("err_spurious_wb", 32'(err_spurious_wb), 32'(m_err));
      end
    end
  end

  initial begin
    bit         r;
    logic [4:0] busy_list[$];
    bit         wv;
    logic [4:0] wa;
    foreach (rf[i]) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rf[5] = 32'h0000_0055;
    @(negedge clk);
    do_reset();

    // busy vector empty after reset: every source register is free
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 5'(i), 5'(31 - i), 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);

    // x0 reads return zero although the register file shows DEADBEEF
    cycle(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("x0_accept", 32'(r), 32'd1);
    chk("x0_op_a", ifc.out_op_a, 32'd0);
    chk("x0_op_b", ifc.out_op_b, 32'd0);

    // RAW stall on x5
    cycle(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("raw_producer", 32'(r), 32'd1);
    cycle(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("raw_stall_held", 32'(r), 32'd0);
    cycle(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("raw_stall_busy", 32'(r), 32'd0);
    cycle(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678, r);
    chk("raw_wb_cycle", 32'(r), 32'(BYP));
    cycle(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("raw_after_wb", 32'(r), 32'd1);
    chk("raw_op_a", ifc.out_op_a, 32'h1234_5678);
    idle(1'b1);
    do_reset();

    // backpressure: held output, stalled decode, accept on release
    cycle(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'hA5A5_0003, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("bp_first", 32'(r), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 32'hA5A5_0004, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, r);
      chk("bp_stall", 32'(r), 32'd0);
      chk("bp_imm_hold", ifc.out_imm, 32'hA5A5_0003);
    end
    cycle(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 32'hA5A5_0004, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("bp_release", 32'(r), 32'd1);
    idle(1'b1);
    do_reset();

    // flush the holder of x7, then a reader of x7 goes straight through
    cycle(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, r);
    cycle(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, r);
    chk("flush_block", 32'(r), 32'd0);
    chk("flush_valid", 32'(ifc.out_valid), 32'd0);
    cycle(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 32'h0000_0009, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("flush_reader", 32'(r), 32'd1);
    idle(1'b1);

    // randomized traffic; writebacks only complete registers the model holds busy
    for (int n = 0; n < 3000; n++) begin
      busy_list.delete();
      for (int k = 1; k < 32; k++) if (mb[k]) busy_list.push_back(5'(k));
      wv = 1'b0;
      wa = 5'd0;
      if ((busy_list.size() > 0) && ($urandom_range(1, 0) == 1)) begin
        wv = 1'b1;
        wa = busy_list[$urandom_range(busy_list.size() - 1, 0)];
      end
      cycle($urandom_range(9, 0) < 7, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
            5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), $urandom,
            $urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0, wv, wa, $urandom, r);
    end

    // reset while a dependent instruction is stalled
    do_reset();
    cycle(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    cycle(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    cycle(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("midstall_stalled", 32'(r), 32'd0);
    do_reset();
    cycle(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r);
    chk("midstall_cleared", 32'(r), 32'd1);
    idle(1'b1);

    // spurious writebacks
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_00AA, r);
    chk("wb_x0_no_err", 32'(err_spurious_wb), 32'd0);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_00BB, r);
    chk("wb_spurious_err", 32'(err_spurious_wb), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("err_sticky", 32'(err_spurious_wb), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
